// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad time-entry front end: key codes,
// entry FSM states, per-position digit limits and small decode helpers.
package keypad_pkg;

  localparam int NUM_KEYS   = 12;
  localparam int NUM_DIGITS = 6;

  localparam logic [3:0] KEY_0    = 4'd0;
  localparam logic [3:0] KEY_1    = 4'd1;
  localparam logic [3:0] KEY_2    = 4'd2;
  localparam logic [3:0] KEY_3    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_7    = 4'd7;
  localparam logic [3:0] KEY_8    = 4'd8;
  localparam logic [3:0] KEY_9    = 4'd9;
  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_DIGIT   = 2'd1,
    WAIT_CONFIRM = 2'd2,
    FULL         = 2'd3
  } entry_state_t;

  // Largest digit allowed at each position H1 H0 M1 M0 S1 S0.
  localparam logic [3:0] POS_LIMIT [0:NUM_DIGITS-1] =
    '{4'd2, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9};
  // Hour units are capped lower once the hour tens digit is 2 (max 23).
  localparam logic [3:0] H0_LIMIT_AFTER_TWO = 4'd3;

  // Map a one-hot keypad vector to its key code; the caller guarantees one-hot.
  function automatic logic [3:0] key_decode(input logic [NUM_KEYS-1:0] keys);
    logic [3:0] code;
    code = KEY_0;
    for (int i = 0; i < 9; i++) begin
      if (keys[i]) code = 4'(i + 1);
    end
    if (keys[9])  code = KEY_STAR;
    if (keys[10]) code = KEY_0;
    if (keys[11]) code = KEY_HASH;
    return code;
  endfunction

  // True when digit may be confirmed at position pos given the hour tens digit.
  function automatic logic digit_legal(input logic [2:0] pos,
                                       input logic [3:0] digit,
                                       input logic [3:0] h1);
    logic [3:0] limit;
    limit = 4'd0;
    if (pos < 3'(NUM_DIGITS)) limit = POS_LIMIT[pos];
    if (pos == 3'd1 && h1 == 4'd2) limit = H0_LIMIT_AFTER_TWO;
    return digit <= limit;
  endfunction

endpackage

// File: rtl/keypad_time_entry_debounce.sv
// Keypad synchroniser and debouncer (module keypad_debounce).
// With KEYPAD_DEBOUNCE_EN defined, a key vector must be seen unchanged on
// DEBOUNCE_CYCLES consecutive synchronised samples before it is passed on;
// otherwise the synchronised vector is passed straight through.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keypad_in,
  output logic [NUM_KEYS-1:0] stable_keys
);

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("keypad_debounce: DEBOUNCE_CYCLES must be within 1..255");
  end

  // Two-flop synchroniser for the asynchronous keypad lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= keypad_in;
      sync2 <= sync1;
    end
  end

`ifdef KEYPAD_DEBOUNCE_EN
  localparam logic [7:0] DB_LIMIT = 8'(DEBOUNCE_CYCLES);

  logic [NUM_KEYS-1:0] last_sample;
  logic [7:0]          run_cnt;
  logic [7:0]          run_next;

  // Length of the current run of identical samples; a change restarts at one.
  always_comb begin
    run_next = run_cnt;
    if (sync2 != last_sample) begin
      run_next = 8'd1;
    end else if (run_cnt != 8'hFF) begin
      run_next = run_cnt + 8'd1;
    end
  end

  // Track the run and accept the vector once it has been steady long enough.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_sample <= '0;
      run_cnt     <= '0;
      stable_keys <= '0;
    end else begin
      last_sample <= sync2;
      run_cnt     <= run_next;
      if (run_next >= DB_LIMIT) stable_keys <= sync2;
    end
  end
`else
  assign stable_keys = sync2;
`endif

endmodule

// File: rtl/keypad_time_entry.sv
// Keypad time entry: turns raw one-hot keypad activity into single key
// presses and assembles a confirmed HH:MM:SS BCD entry for the controller.
// Optional macro KEYPAD_DEBOUNCE_EN enables the debounce counter.
module keypad_time_entry
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [NUM_KEYS-1:0] keypad_in,
  output logic                key_valid,
  output logic [3:0]          key_code,
  output logic [7:0]          hour_bcd,
  output logic [7:0]          min_bcd,
  output logic [7:0]          sec_bcd,
  output logic [2:0]          digit_cnt,
  output logic                entry_done,
  output logic                entry_err
);

  logic [NUM_KEYS-1:0] stable_keys;
  logic                key_pressed;
  logic                prev_pressed;

  entry_state_t                 state_q, state_d;
  logic [NUM_DIGITS-1:0][3:0]   buf_q, buf_d;
  logic [3:0]                   pending_q, pending_d;
  logic [2:0]                   cnt_d;
  logic [7:0]                   hour_d, min_d, sec_d;
  logic                         done_d, err_d;
  logic                         is_digit;

  keypad_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .keypad_in  (keypad_in),
    .stable_keys(stable_keys)
  );

  // Chords and all-released both count as "no key".
  assign key_pressed = $onehot(stable_keys);
  assign is_digit    = (key_code <= KEY_9);

  // One pulse per released-to-pressed edge, latching the decoded key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_pressed <= 1'b0;
      key_valid    <= 1'b0;
      key_code     <= KEY_0;
    end else begin
      prev_pressed <= key_pressed;
      key_valid    <= key_pressed && !prev_pressed;
      if (key_pressed && !prev_pressed) key_code <= key_decode(stable_keys);
    end
  end

  // Entry FSM: next state, digit buffer updates, commit and error pulses.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    pending_d = pending_q;
    cnt_d     = digit_cnt;
    hour_d    = hour_bcd;
    min_d     = min_bcd;
    sec_d     = sec_bcd;
    done_d    = 1'b0;
    err_d     = 1'b0;
    if (!enable) begin
      state_d   = IDLE;
      buf_d     = '0;
      pending_d = '0;
      cnt_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: state_d = WAIT_DIGIT;
        WAIT_DIGIT: begin
          if (key_valid) begin
            if (is_digit) begin
              pending_d = key_code;
              state_d   = WAIT_CONFIRM;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        WAIT_CONFIRM: begin
          if (key_valid) begin
            if (is_digit) begin
              pending_d = key_code;
            end else if (key_code == KEY_HASH &&
                         digit_legal(digit_cnt, pending_q, buf_q[0])) begin
              buf_d[digit_cnt] = pending_q;
              cnt_d            = digit_cnt + 3'd1;
              state_d          = (digit_cnt == 3'(NUM_DIGITS - 1)) ? FULL : WAIT_DIGIT;
            end else begin
              err_d   = 1'b1;
              state_d = WAIT_DIGIT;
            end
          end
        end
        FULL: begin
          if (key_valid) begin
            if (key_code == KEY_STAR) begin
              hour_d  = {buf_q[0], buf_q[1]};
              min_d   = {buf_q[2], buf_q[3]};
              sec_d   = {buf_q[4], buf_q[5]};
              done_d  = 1'b1;
              cnt_d   = '0;
              state_d = WAIT_DIGIT;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Entry state, buffer and committed outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      buf_q      <= '0;
      pending_q  <= '0;
      digit_cnt  <= '0;
      hour_bcd   <= '0;
      min_bcd    <= '0;
      sec_bcd    <= '0;
      entry_done <= 1'b0;
      entry_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      pending_q  <= pending_d;
      digit_cnt  <= cnt_d;
      hour_bcd   <= hour_d;
      min_bcd    <= min_d;
      sec_bcd    <= sec_d;
      entry_done <= done_d;
      entry_err  <= err_d;
    end
  end

endmodule
